// File: rtl/result_accumulator_pkg.sv
// Shared types, sizes and saturating/ReLU helpers for the result accumulator and
// later post-processing stages.
package result_accumulator_pkg;

    localparam int MATRIX_SIZE    = 8;
    localparam int PARTIAL_SUM_BW = 20;
    localparam int ACC_BW         = 24;
    localparam int ACC_DEPTH      = 8;
    localparam int ROW_AW         = $clog2(ACC_DEPTH);
    localparam int OUT_FIFO_DEPTH = 2;
    localparam int FIFO_CW        = $clog2(OUT_FIFO_DEPTH + 1);
    localparam int ROW_DATA_BW    = ACC_BW * MATRIX_SIZE;
    localparam int FIFO_WIDTH     = ROW_AW + ROW_DATA_BW;

    typedef logic signed [ACC_BW-1:0] acc_lane_t;

    localparam acc_lane_t ACC_MAX = {1'b0, {(ACC_BW-1){1'b1}}};
    localparam acc_lane_t ACC_MIN = {1'b1, {(ACC_BW-1){1'b0}}};

    typedef struct packed {
        logic [ROW_AW-1:0]      row;
        logic [ROW_DATA_BW-1:0] data;
    } out_entry_t;

    function automatic acc_lane_t sext_psum(input logic [PARTIAL_SUM_BW-1:0] p);
        return {{(ACC_BW-PARTIAL_SUM_BW){p[PARTIAL_SUM_BW-1]}}, p};
    endfunction

    // One extra bit holds the exact sum; the top two bits disagree only on overflow.
    function automatic logic sat_ovf(input acc_lane_t a, input acc_lane_t b);
        logic [ACC_BW:0] wide;
        wide = {a[ACC_BW-1], a} + {b[ACC_BW-1], b};
        return (wide[ACC_BW] != wide[ACC_BW-1]);
    endfunction

    function automatic acc_lane_t sat_add(input acc_lane_t a, input acc_lane_t b);
        logic [ACC_BW:0] wide;
        acc_lane_t       res;
        wide = {a[ACC_BW-1], a} + {b[ACC_BW-1], b};
        if (wide[ACC_BW] != wide[ACC_BW-1]) begin
            if (wide[ACC_BW]) begin
                res = ACC_MIN;
            end else begin
                res = ACC_MAX;
            end
        end else begin
            res = wide[ACC_BW-1:0];
        end
        return res;
    endfunction

    function automatic acc_lane_t relu(input acc_lane_t x);
        acc_lane_t res;
        if (x[ACC_BW-1]) begin
            res = {ACC_BW{1'b0}};
        end else begin
            res = x;
        end
        return res;
    endfunction

endpackage

// File: rtl/result_accumulator_out_fifo.sv
// Small synchronous FIFO for emitted rows. The head entry is held in a register so
// the consumer sees stable registered outputs, and the last value persists when empty.
module acc_out_fifo
    import result_accumulator_pkg::*;
#(
    parameter int  WIDTH = FIFO_WIDTH,
    parameter int  DEPTH = OUT_FIFO_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    rd_ptr_next_s;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_after_pop_s;
    logic [CW-1:0]    count_next_s;
    logic             push_ok_s;
    logic             pop_ok_s;
    logic             full_s;
    logic             empty_s;
    logic             valid_r;
    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] head_next_s;

    // Occupancy, guarded push/pop and next head selection.
    always_comb begin
        full_s            = (count_r == CW'(DEPTH));
        empty_s           = (count_r == {CW{1'b0}});
        push_ok_s         = push & ~full_s;
        pop_ok_s          = pop & ~empty_s;
        rd_ptr_next_s     = rd_ptr_r;
        count_after_pop_s = count_r;
        count_next_s      = count_r;
        head_next_s       = head_r;
        if (pop_ok_s) begin
            rd_ptr_next_s     = rd_ptr_r + AW'(1);
            count_after_pop_s = count_r - CW'(1);
        end else begin
            rd_ptr_next_s     = rd_ptr_r;
            count_after_pop_s = count_r;
        end
        if (push_ok_s) begin
            count_next_s = count_after_pop_s + CW'(1);
        end else begin
            count_next_s = count_after_pop_s;
        end
        // A push into an otherwise drained FIFO becomes the head directly.
        if (count_next_s == {CW{1'b0}}) begin
            head_next_s = head_r;
        end else if (count_after_pop_s == {CW{1'b0}}) begin
            head_next_s = push_data;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // Pointer, count and head registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            valid_r  <= 1'b0;
            head_r   <= {WIDTH{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            rd_ptr_r <= rd_ptr_next_s;
            count_r  <= count_next_s;
            valid_r  <= (count_next_s != {CW{1'b0}});
            head_r   <= head_next_s;
        end
    end

    // Entry storage; occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (rstn && push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign head_valid = valid_r;
    assign head_data  = head_r;
    assign count      = count_r;
    assign full       = full_s;
    assign empty      = empty_s;

endmodule

// File: rtl/result_accumulator.sv
// Accumulates deskewed partial-sum rows across K-tiles into a per-row bank and queues
// finished (optionally ReLU'd) rows for the result SRAM writer.
module result_accumulator
    import result_accumulator_pkg::*;
(
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] in_data,
    input  logic [ROW_AW-1:0]                     in_row,
    input  logic                                  in_first,
    input  logic                                  in_last,
    input  logic                                  relu_en,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [ROW_DATA_BW-1:0]                out_data,
    output logic [ROW_AW-1:0]                     out_row,
    input  logic                                  clr_flags,
    output logic                                  ovf_flag,
    output logic [15:0]                           emit_count
);

    acc_lane_t          acc_r [ACC_DEPTH][MATRIX_SIZE];
    acc_lane_t          base_s [MATRIX_SIZE];
    acc_lane_t          addend_s [MATRIX_SIZE];
    acc_lane_t          sum_s [MATRIX_SIZE];
    logic [MATRIX_SIZE-1:0] lane_ovf_s;
    logic [ROW_DATA_BW-1:0] emit_data_s;
    out_entry_t         push_entry_s;
    out_entry_t         head_entry_s;
    logic [FIFO_WIDTH-1:0]  fifo_head_s;
    logic [FIFO_CW-1:0] fifo_count_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic               fifo_valid_s;
    logic               in_ready_s;
    logic               accept_s;
    logic               push_s;
    logic               pop_s;
    logic               ovf_r;
    logic [15:0]        emit_count_r;

    // Handshake decode; readiness depends only on the registered FIFO count.
    always_comb begin
        in_ready_s = (fifo_count_s < FIFO_CW'(OUT_FIFO_DEPTH));
        accept_s   = in_valid & in_ready_s;
        push_s     = accept_s & in_last & ~fifo_full_s;
        pop_s      = out_ready & ~fifo_empty_s;
    end

    // Lane-wise saturating update and optional ReLU on the emitted copy.
    always_comb begin
        lane_ovf_s   = {MATRIX_SIZE{1'b0}};
        emit_data_s  = {ROW_DATA_BW{1'b0}};
        push_entry_s = '{row: {ROW_AW{1'b0}}, data: {ROW_DATA_BW{1'b0}}};
        for (int i = 0; i < MATRIX_SIZE; i++) begin
            base_s[i]   = {ACC_BW{1'b0}};
            addend_s[i] = sext_psum(in_data[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW]);
            if (in_first) begin
                base_s[i] = {ACC_BW{1'b0}};
            end else begin
                base_s[i] = acc_r[in_row][i];
            end
            sum_s[i]      = sat_add(base_s[i], addend_s[i]);
            lane_ovf_s[i] = sat_ovf(base_s[i], addend_s[i]);
            if (relu_en) begin
                emit_data_s[i*ACC_BW +: ACC_BW] = relu(sum_s[i]);
            end else begin
                emit_data_s[i*ACC_BW +: ACC_BW] = sum_s[i];
            end
        end
        push_entry_s.row  = in_row;
        push_entry_s.data = emit_data_s;
    end

    // Accumulator bank; the stored value is the saturated pre-ReLU sum.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int r = 0; r < ACC_DEPTH; r++) begin
                for (int i = 0; i < MATRIX_SIZE; i++) begin
                    acc_r[r][i] <= {ACC_BW{1'b0}};
                end
            end
        end else if (accept_s) begin
            for (int i = 0; i < MATRIX_SIZE; i++) begin
                acc_r[in_row][i] <= sum_s[i];
            end
        end
    end

    // Sticky overflow flag (clear wins over a same-cycle set) and emission counter.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ovf_r        <= 1'b0;
            emit_count_r <= 16'd0;
        end else begin
            if (clr_flags) begin
                ovf_r <= 1'b0;
            end else if (accept_s && (lane_ovf_s != {MATRIX_SIZE{1'b0}})) begin
                ovf_r <= 1'b1;
            end
            if (push_s) begin
                emit_count_r <= emit_count_r + 16'd1;
            end
        end
    end

    acc_out_fifo #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (OUT_FIFO_DEPTH)
    ) u_out_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push       (push_s),
        .push_data  (push_entry_s),
        .pop        (pop_s),
        .head_valid (fifo_valid_s),
        .head_data  (fifo_head_s),
        .count      (fifo_count_s),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s)
    );

    assign head_entry_s = fifo_head_s;
    assign in_ready     = in_ready_s;
    assign out_valid    = fifo_valid_s;
    assign out_data     = head_entry_s.data;
    assign out_row      = head_entry_s.row;
    assign ovf_flag     = ovf_r;
    assign emit_count   = emit_count_r;

endmodule

// File: tb/tb_result_accumulator.sv
// Directed bench for result_accumulator: a vector table for single-row behaviour plus
// hand sequences for saturation, backpressure and mid-operation reset.
module tb_result_accumulator;

    logic         clk = 1'b0;
    logic         rstn;
    logic         in_valid;
    logic         in_ready;
    logic [159:0] in_data;
    logic [2:0]   in_row;
    logic         in_first;
    logic         in_last;
    logic         relu_en;
    logic         out_valid;
    logic         out_ready;
    logic [191:0] out_data;
    logic [2:0]   out_row;
    logic         clr_flags;
    logic         ovf_flag;
    logic [15:0]  emit_count;

    int checks = 0;
    int failures = 0;
    int exp_emits = 0;

    typedef struct {
        logic [2:0]   row;
        logic         first;
        logic         last;
        logic         relu;
        int           base;
        int           step;
        logic [191:0] exp;
    } vec_t;

    vec_t vt[16];

    logic         rec_en = 1'b0;
    logic [2:0]   rec_row[$];
    logic [191:0] rec_data[$];

    result_accumulator dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_row     (in_row),
        .in_first   (in_first),
        .in_last    (in_last),
        .relu_en    (relu_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_row    (out_row),
        .clr_flags  (clr_flags),
        .ovf_flag   (ovf_flag),
        .emit_count (emit_count)
    );

    always #5 clk = ~clk;

    // Record every pop that the next rising edge will perform.
    always @(negedge clk) begin
        if (rec_en && out_valid && out_ready) begin
            rec_row.push_back(out_row);
            rec_data.push_back(out_data);
        end
    end

    function automatic logic [191:0] exp8(input int a0, input int a1, input int a2, input int a3,
                                          input int a4, input int a5, input int a6, input int a7);
        return {24'(a7), 24'(a6), 24'(a5), 24'(a4), 24'(a3), 24'(a2), 24'(a1), 24'(a0)};
    endfunction

    function automatic logic [191:0] expu(input int v);
        return exp8(v, v, v, v, v, v, v, v);
    endfunction

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Offer one row (lane i = base + i*step) and hold it until accepted, bounded.
    task automatic send(input logic [2:0] row, input logic first, input logic last,
                        input logic relu, input int base, input int step);
        bit ok;
        in_valid = 1'b1;
        in_row   = row;
        in_first = first;
        in_last  = last;
        relu_en  = relu;
        for (int i = 0; i < 8; i++) begin
            in_data[i*20 +: 20] = 20'(base + i * step);
        end
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
            if (last) exp_emits++;
        end else begin
            checks++;
            failures++;
            $display("FAIL send_timeout: row %0d never accepted, in_ready stayed %0b (required 1)", row, in_ready);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; in_valid = 1'b0; in_data = '0; in_row = 3'd0; in_first = 1'b0;
        in_last = 1'b0; relu_en = 1'b0; out_ready = 1'b1; clr_flags = 1'b0;

        vt[0]  = '{3'd3, 1'b1, 1'b0, 1'b0, 5, 0, '0};
        vt[1]  = '{3'd3, 1'b0, 1'b0, 1'b0, 5, 0, '0};
        vt[2]  = '{3'd3, 1'b0, 1'b1, 1'b0, 5, 0, expu(15)};
        vt[3]  = '{3'd1, 1'b1, 1'b1, 1'b1, -7, 0, expu(0)};
        vt[4]  = '{3'd1, 1'b1, 1'b1, 1'b0, -7, 0, expu(-7)};
        vt[5]  = '{3'd2, 1'b1, 1'b1, 1'b1, -3, 2, exp8(0, 0, 1, 3, 5, 7, 9, 11)};
        vt[6]  = '{3'd4, 1'b1, 1'b0, 1'b0, 100, -10, '0};
        vt[7]  = '{3'd4, 1'b0, 1'b1, 1'b0, -200, 0, exp8(-100, -110, -120, -130, -140, -150, -160, -170)};
        vt[8]  = '{3'd6, 1'b1, 1'b0, 1'b0, 10, -3, '0};
        vt[9]  = '{3'd6, 1'b0, 1'b1, 1'b1, 0, 0, exp8(10, 7, 4, 1, 0, 0, 0, 0)};
        vt[10] = '{3'd0, 1'b1, 1'b0, 1'b0, 1, 0, '0};
        vt[11] = '{3'd7, 1'b1, 1'b0, 1'b0, 2, 0, '0};
        vt[12] = '{3'd0, 1'b0, 1'b1, 1'b0, 1, 0, expu(2)};
        vt[13] = '{3'd7, 1'b0, 1'b1, 1'b0, 3, 0, expu(5)};
        vt[14] = '{3'd3, 1'b1, 1'b1, 1'b0, 9, 0, expu(9)};
        vt[15] = '{3'd3, 1'b1, 1'b1, 1'b0, -524288, 0, expu(-524288)};

        // Reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 192'(out_valid), 192'(1'b0));
        chk("rst_in_ready", 192'(in_ready), 192'(1'b1));
        chk("rst_ovf", 192'(ovf_flag), 192'(1'b0));
        chk("rst_emit_count", 192'(emit_count), 192'(16'd0));
        chk("rst_out_data", out_data, 192'(0));
        chk("rst_out_row", 192'(out_row), 192'(3'd0));
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Table: one accept per vector, consumer always ready
        for (int v = 0; v < 16; v++) begin
            send(vt[v].row, vt[v].first, vt[v].last, vt[v].relu, vt[v].base, vt[v].step);
            chk($sformatf("vec%0d_out_valid", v), 192'(out_valid), 192'(vt[v].last));
            if (vt[v].last) begin
                chk($sformatf("vec%0d_out_row", v), 192'(out_row), 192'(vt[v].row));
                chk($sformatf("vec%0d_out_data", v), out_data, vt[v].exp);
            end
        end
        @(posedge clk);
        #1;
        chk("empty_out_valid", 192'(out_valid), 192'(1'b0));
        chk("empty_hold_data", out_data, vt[15].exp);
        chk("empty_hold_row", 192'(out_row), 192'(3'd3));
        chk("table_emit_count", 192'(emit_count), 192'(16'(exp_emits)));
        chk("table_ovf", 192'(ovf_flag), 192'(1'b0));

        // Positive saturation over 32 tiles
        for (int t = 1; t <= 32; t++) begin
            send(3'd2, t == 1, t == 32, 1'b0, 524287, 0);
            if (t == 16) chk("sat_t16_ovf", 192'(ovf_flag), 192'(1'b0));
            if (t == 17) chk("sat_t17_ovf", 192'(ovf_flag), 192'(1'b1));
        end
        chk("sat_out_valid", 192'(out_valid), 192'(1'b1));
        chk("sat_out_row", 192'(out_row), 192'(3'd2));
        chk("sat_out_data", out_data, expu(8388607));
        chk("sat_ovf", 192'(ovf_flag), 192'(1'b1));
        clr_flags = 1'b1;
        @(posedge clk);
        #1;
        clr_flags = 1'b0;
        chk("clr_ovf", 192'(ovf_flag), 192'(1'b0));

        // Negative boundary: exactly the minimum, then one step beyond
        for (int t = 1; t <= 16; t++) begin
            send(3'd5, t == 1, t == 16, 1'b0, -524288, 0);
        end
        chk("negmin_out_data", out_data, expu(-8388608));
        chk("negmin_ovf", 192'(ovf_flag), 192'(1'b0));
        clr_flags = 1'b1;
        send(3'd5, 1'b0, 1'b1, 1'b0, -1, 0);
        clr_flags = 1'b0;
        chk("negsat_clr_out_data", out_data, expu(-8388608));
        chk("negsat_clr_priority", 192'(ovf_flag), 192'(1'b0));
        send(3'd5, 1'b0, 1'b1, 1'b0, -1, 0);
        chk("negsat_ovf", 192'(ovf_flag), 192'(1'b1));
        chk("sat_emit_count", 192'(emit_count), 192'(16'(exp_emits)));
        clr_flags = 1'b1;
        @(posedge clk);
        #1;
        clr_flags = 1'b0;

        // Backpressure: two rows fill the FIFO, the third waits
        out_ready = 1'b0;
        rec_en = 1'b1;
        send(3'd0, 1'b1, 1'b1, 1'b0, 10, 1);
        chk("bp_valid_after_first", 192'(out_valid), 192'(1'b1));
        chk("bp_ready_after_first", 192'(in_ready), 192'(1'b1));
        send(3'd1, 1'b1, 1'b1, 1'b0, 20, 1);
        chk("bp_full_in_ready", 192'(in_ready), 192'(1'b0));
        fork
            send(3'd2, 1'b1, 1'b1, 1'b0, 30, 1);
            begin
                repeat (3) @(negedge clk);
                chk("bp_hold_in_ready", 192'(in_ready), 192'(1'b0));
                chk("bp_hold_head_row", 192'(out_row), 192'(3'd0));
                chk("bp_hold_emit_count", 192'(emit_count), 192'(16'(exp_emits)));
                out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        rec_en = 1'b0;
        chk("bp_drain_count", 192'(rec_row.size()), 192'(3));
        for (int k = 0; k < 3; k++) begin
            if (k < rec_row.size()) begin
                chk($sformatf("bp_drain%0d_row", k), 192'(rec_row[k]), 192'(k));
                chk($sformatf("bp_drain%0d_data", k), rec_data[k],
                    exp8(10*(k+1), 10*(k+1)+1, 10*(k+1)+2, 10*(k+1)+3,
                         10*(k+1)+4, 10*(k+1)+5, 10*(k+1)+6, 10*(k+1)+7));
            end
        end
        chk("bp_emit_count", 192'(emit_count), 192'(16'(exp_emits)));
        chk("bp_empty_after_drain", 192'(out_valid), 192'(1'b0));

        // Mid-operation reset discards accumulation and queued rows
        out_ready = 1'b0;
        send(3'd5, 1'b1, 1'b0, 1'b0, 4, 0);
        send(3'd5, 1'b0, 1'b0, 1'b0, 4, 0);
        send(3'd1, 1'b1, 1'b1, 1'b0, 33, 0);
        chk("mid_queued_valid", 192'(out_valid), 192'(1'b1));
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        exp_emits = 0;
        chk("mid_rst_out_valid", 192'(out_valid), 192'(1'b0));
        chk("mid_rst_out_data", out_data, 192'(0));
        chk("mid_rst_out_row", 192'(out_row), 192'(3'd0));
        chk("mid_rst_emit_count", 192'(emit_count), 192'(16'd0));
        chk("mid_rst_in_ready", 192'(in_ready), 192'(1'b1));
        out_ready = 1'b1;
        send(3'd5, 1'b0, 1'b1, 1'b0, 1, 0);
        chk("mid_acc_cleared", out_data, expu(1));
        chk("mid_acc_row", 192'(out_row), 192'(3'd5));
        send(3'd5, 1'b1, 1'b1, 1'b0, 1, 0);
        chk("mid_single_tile", out_data, expu(1));
        chk("mid_emit_count", 192'(emit_count), 192'(16'(exp_emits)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
